// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage and the data memory / interconnect.
// master: drives req/we/addr/be/wdata; receives gnt/rvalid/rdata.
// slave : the memory side of the same signals.
interface mem_access_stage_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [3:0]            dmem_be;
  logic [31:0]           dmem_wdata;
  logic                  dmem_gnt;
  logic                  dmem_rvalid;
  logic [31:0]           dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: runs loads/stores on a req/gnt/rvalid data bus, aligns
// store lanes, formats load data, and registers the MEM/WB bundle.
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   i_alu_result ..   execute-stage outputs (address/result, store data, rd, controls)
//   dmem              data-memory bus (master side)
//   o_mem_stall       combinational freeze request to upstream stages
//   o_wb_*            registered writeback bundle
//   o_misalign_err    1-cycle pulse: misaligned access dropped
//   o_bus_err         1-cycle pulse: load response watchdog abort
module mem_access_stage #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               i_alu_result,
  input  logic [31:0]               i_write_data,
  input  logic [4:0]                i_dr_num,
  input  logic [31:0]               i_pc_plus_4,
  input  logic [1:0]                i_result_src,
  input  logic                      i_mem_write,
  input  logic                      i_mem_read,
  input  logic                      i_reg_write,
  input  logic [2:0]                i_funct3,
  mem_access_stage_if.master        dmem,
  output logic                      o_mem_stall,
  output logic [31:0]               o_wb_result,
  output logic [4:0]                o_wb_dr_num,
  output logic                      o_wb_reg_write,
  output logic                      o_misalign_err,
  output logic                      o_bus_err
);

  localparam int unsigned WDOG_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned WDOG_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic {
    S_IDLE,
    S_WAIT_RESP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WDOG_W-1:0]   r_wdog;
  logic [WDOG_W-1:0]   w_wdog_nxt;
  logic [31:0]         r_wb_result;
  logic [4:0]          r_wb_dr_num;
  logic                r_wb_reg_write;
  logic                r_misalign_err;
  logic                r_bus_err;

  logic                w_access;
  logic                w_misaligned;
  logic [1:0]          w_byte_off;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata;
  logic [31:0]         w_shifted;
  logic [31:0]         w_load_data;
  logic [31:0]         w_sel_result;
  logic                w_timeout;
  logic                w_req;
  logic                w_stall;
  logic                w_wb_pass;
  logic                w_wb_load;
  logic                w_err_mis;
  logic                w_err_bus;

  assign w_access   = i_mem_read | i_mem_write;
  assign w_byte_off = i_alu_result[1:0];

  // Size decode: funct3[1:0] 00 byte, 01 half, otherwise word.
  always_comb begin
    w_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_wdata      = i_write_data;
    case (i_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_byte_off;
        w_wdata = {4{i_write_data[7:0]}};
      end
      2'b01: begin
        w_misaligned = w_byte_off[0];
        w_be         = w_byte_off[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{i_write_data[15:0]}};
      end
      default: begin
        w_misaligned = (w_byte_off != 2'b00);
      end
    endcase
  end

  // Load formatting: move the addressed lane to bit 0, then extend.
  assign w_shifted = dmem.dmem_rdata >> {w_byte_off, 3'b000};

  always_comb begin
    w_load_data = w_shifted;
    case (i_funct3)
      3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
      3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  // Pass-through result; result_src 11 aliases 00, 01 outside a load completion falls back to ALU.
  assign w_sel_result = (i_result_src == 2'b10) ? i_pc_plus_4 : i_alu_result;

  assign w_timeout = (TIMEOUT != 0) && (r_wdog == WDOG_W'(WDOG_LAST));

  // Next-state and control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_wdog_nxt  = r_wdog;
    w_req       = 1'b0;
    w_stall     = 1'b0;
    w_wb_pass   = 1'b0;
    w_wb_load   = 1'b0;
    w_err_mis   = 1'b0;
    w_err_bus   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_wdog_nxt = '0;
        if (w_access && !w_misaligned) begin
          w_req = 1'b1;
          if (dmem.dmem_gnt && i_mem_write) begin
            w_wb_pass = 1'b1;
          end else if (dmem.dmem_gnt) begin
            w_stall     = 1'b1;
            w_state_nxt = S_WAIT_RESP;
          end else begin
            w_stall = 1'b1;
          end
        end else if (w_access) begin
          w_err_mis = 1'b1;
        end else begin
          w_wb_pass = 1'b1;
        end
      end
      S_WAIT_RESP: begin
        if (dmem.dmem_rvalid) begin
          w_wb_load   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_err_bus   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_stall    = 1'b1;
          w_wdog_nxt = r_wdog + WDOG_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, watchdog and MEM/WB registers; non-loading edges insert a bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_wdog         <= '0;
      r_wb_result    <= '0;
      r_wb_dr_num    <= '0;
      r_wb_reg_write <= 1'b0;
      r_misalign_err <= 1'b0;
      r_bus_err      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_wdog         <= w_wdog_nxt;
      r_misalign_err <= w_err_mis;
      r_bus_err      <= w_err_bus;
      if (w_wb_pass || w_wb_load) begin
        r_wb_result    <= w_wb_load ? w_load_data : w_sel_result;
        r_wb_dr_num    <= i_dr_num;
        r_wb_reg_write <= i_reg_write;
      end else begin
        r_wb_reg_write <= 1'b0;
      end
    end
  end

  // Request and stall are gated by reset so nothing leaks out during reset.
  assign dmem.dmem_req   = reset & w_req;
  assign dmem.dmem_we    = i_mem_write;
  assign dmem.dmem_addr  = {i_alu_result[ADDR_WIDTH-1:2], 2'b00};
  assign dmem.dmem_be    = w_be;
  assign dmem.dmem_wdata = w_wdata;
  assign o_mem_stall     = reset & w_stall;

  assign o_wb_result    = r_wb_result;
  assign o_wb_dr_num    = r_wb_dr_num;
  assign o_wb_reg_write = r_wb_reg_write;
  assign o_misalign_err = r_misalign_err;
  assign o_bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage with a transaction-level reference model.
module tb_mem_access_stage;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        reset;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [4:0]  dr_num;
  logic [31:0] pc_plus_4;
  logic [1:0]  result_src;
  logic        mem_write;
  logic        mem_read;
  logic        reg_write;
  logic [2:0]  funct3;
  logic        mem_stall;
  logic [31:0] wb_result;
  logic [4:0]  wb_dr_num;
  logic        wb_reg_write;
  logic        misalign_err;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  // Expected MEM/WB state.
  logic [31:0] m_res;
  logic [4:0]  m_rd;
  logic        m_we;

  mem_access_stage_if #(.ADDR_WIDTH(32)) bus ();

  mem_access_stage #(.ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_alu_result   (alu_result),
    .i_write_data   (write_data),
    .i_dr_num       (dr_num),
    .i_pc_plus_4    (pc_plus_4),
    .i_result_src   (result_src),
    .i_mem_write    (mem_write),
    .i_mem_read     (mem_read),
    .i_reg_write    (reg_write),
    .i_funct3       (funct3),
    .dmem           (bus),
    .o_mem_stall    (mem_stall),
    .o_wb_result    (wb_result),
    .o_wb_dr_num    (wb_dr_num),
    .o_wb_reg_write (wb_reg_write),
    .o_misalign_err (misalign_err),
    .o_bus_err      (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] load_fmt(input logic [31:0] rd, input logic [1:0] a,
                                           input logic [2:0] f3);
    logic [31:0] s;
    s = rd >> (8 * a);
    case (f3)
      3'd0: begin s = s % 256;   if (s >= 128)   s = s - 256;   end
      3'd1: begin s = s % 65536; if (s >= 32768) s = s - 65536; end
      3'd4: s = s % 256;
      3'd5: s = s % 65536;
      default: ;
    endcase
    return s;
  endfunction

  // One instruction through the stage; gnt after gnt_dly cycles, rvalid after
  // rv_dly waiting cycles (negative = never), stray = rvalid pulses outside a wait.
  task automatic do_op(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] pc4, input logic [1:0] rs, input logic mw,
                       input logic mr, input logic rw, input logic [2:0] f3,
                       input int gnt_dly, input int rv_dly, input bit stray,
                       input logic [31:0] rdata);
    int c = 0, w = 0, cyc = 0, sz;
    bit waiting = 0, done = 0, acc, mis, exp_req, exp_stall, tmo, e_mis, e_bus;
    logic [1:0]  a;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_ld, sel;
    alu_result = alu; write_data = wd; dr_num = rd; pc_plus_4 = pc4; result_src = rs;
    mem_write = mw; mem_read = mr; reg_write = rw; funct3 = f3;
    a      = alu[1:0];
    acc    = mr | mw;
    sz     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis    = acc && ((a % sz) != 0);
    exp_be = (sz == 1) ? (4'b0001 << a) : (sz == 2) ? (4'b0011 << a) : 4'b1111;
    exp_wd = (sz == 1) ? wd[7:0] * 32'h01010101 : (sz == 2) ? wd[15:0] * 32'h00010001 : wd;
    exp_ld = load_fmt(rdata, a, f3);
    sel    = (rs == 2'b10) ? pc4 : alu;
    while (!done) begin
      bus.dmem_gnt    = !waiting && acc && !mis && (c == gnt_dly);
      bus.dmem_rvalid = waiting ? (rv_dly >= 0 && w == rv_dly) : stray;
      bus.dmem_rdata  = bus.dmem_rvalid ? rdata : $urandom;
      @(negedge clk);
      exp_req   = !waiting && acc && !mis;
      tmo       = waiting && !bus.dmem_rvalid && (w == TO - 1);
      exp_stall = waiting ? (!bus.dmem_rvalid && !tmo) : (exp_req && !(bus.dmem_gnt && mw));
      check_eq("req", 32'(bus.dmem_req), 32'(exp_req));
      check_eq("stall", 32'(mem_stall), 32'(exp_stall));
      if (exp_req) begin
        check_eq("we", 32'(bus.dmem_we), 32'(mw));
        check_eq("addr", bus.dmem_addr, {alu[31:2], 2'b00});
        check_eq("be", 32'(bus.dmem_be), 32'(exp_be));
        if (mw) check_eq("wdata", bus.dmem_wdata, exp_wd);
      end
      e_mis = 0; e_bus = 0;
      if (!waiting) begin
        if (!acc || (!mis && bus.dmem_gnt && mw)) begin
          m_res = sel; m_rd = rd; m_we = rw; done = 1;
        end else if (mis) begin
          m_we = 0; e_mis = 1; done = 1;
        end else if (bus.dmem_gnt) begin
          m_we = 0; waiting = 1;
        end else begin
          m_we = 0; c++;
        end
      end else begin
        if (bus.dmem_rvalid) begin
          m_res = exp_ld; m_rd = rd; m_we = rw; done = 1;
        end else if (tmo) begin
          m_we = 0; e_bus = 1; done = 1;
        end else begin
          m_we = 0; w++;
        end
      end
      @(posedge clk); #1;
      check_eq("wb_result", wb_result, m_res);
      check_eq("wb_dr_num", 32'(wb_dr_num), 32'(m_rd));
      check_eq("wb_reg_write", 32'(wb_reg_write), 32'(m_we));
      check_eq("misalign_err", 32'(misalign_err), 32'(e_mis));
      check_eq("bus_err", 32'(bus_err), 32'(e_bus));
      cyc++;
      if (!done && cyc > 50) begin
        check_eq("op_budget", 32'(cyc), 32'd50);
        done = 1;
      end
    end
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
  endtask

  initial begin
    int kind, gd, rvd;
    logic [2:0]  f3;
    logic [31:0] base;
    reset = 1'b0;
    alu_result = '0; write_data = '0; dr_num = '0; pc_plus_4 = '0; result_src = '0;
    mem_write = 1'b0; mem_read = 1'b1; reg_write = 1'b0; funct3 = 3'd2;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
    m_res = '0; m_rd = '0; m_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", 32'(bus.dmem_req), 32'd0);
    check_eq("rst_stall", 32'(mem_stall), 32'd0);
    check_eq("rst_wb_result", wb_result, 32'd0);
    check_eq("rst_wb_we", 32'(wb_reg_write), 32'd0);
    check_eq("rst_errs", 32'({misalign_err, bus_err}), 32'd0);
    mem_read = 1'b0;
    reset = 1'b1;

    // Directed cases.
    do_op(32'h100, 32'hDEADBEEF, 5'd0, 32'h4, 2'b00, 1, 0, 0, 3'd2, 0, 0, 0, 0);           // SW
    do_op(32'h103, 0, 5'd3, 32'h8, 2'b01, 0, 1, 1, 3'd0, 0, 1, 0, 32'h80ABCD12);           // LB
    do_op(32'h102, 0, 5'd4, 32'h8, 2'b01, 0, 1, 1, 3'd5, 1, 0, 0, 32'hBEEF1234);           // LHU
    do_op(32'h102, 0, 5'd5, 32'h8, 2'b01, 0, 1, 1, 3'd1, 0, 2, 0, 32'hBEEF1234);           // LH
    do_op(32'h101, 32'h1234, 5'd6, 32'h8, 2'b00, 1, 0, 1, 3'd1, 0, 0, 0, 0);               // SH misaligned
    do_op(32'h202, 32'h55, 5'd0, 32'h8, 2'b00, 1, 0, 0, 3'd0, 3, 0, 0, 0);                 // SB, gnt late
    do_op(32'h300, 0, 5'd7, 32'h8, 2'b01, 0, 1, 1, 3'd2, 0, -1, 0, 32'h11111111);          // LW timeout
    do_op(32'h1234, 0, 5'd8, 32'h40, 2'b10, 0, 0, 1, 3'd0, 0, 0, 1, 32'h22222222);         // late rvalid
    do_op(32'h5678, 0, 5'd9, 32'h44, 2'b11, 0, 0, 1, 3'd0, 0, 0, 0, 0);                    // src 11

    // Reset while waiting for a load response.
    alu_result = 32'h400; mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1;
    funct3 = 3'd2; dr_num = 5'd10; result_src = 2'b01;
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    check_eq("rw_req", 32'(bus.dmem_req), 32'd1);
    @(posedge clk); #1;
    bus.dmem_gnt = 1'b0;
    @(negedge clk);
    check_eq("rw_wait_stall", 32'(mem_stall), 32'd1);
    check_eq("rw_wait_req", 32'(bus.dmem_req), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("rw_rst_stall", 32'(mem_stall), 32'd0);
    check_eq("rw_rst_req", 32'(bus.dmem_req), 32'd0);
    @(posedge clk); #1;
    check_eq("rw_wb_result", wb_result, 32'd0);
    check_eq("rw_wb_dr", 32'(wb_dr_num), 32'd0);
    check_eq("rw_wb_we", 32'(wb_reg_write), 32'd0);
    check_eq("rw_errs", 32'({misalign_err, bus_err}), 32'd0);
    reset = 1'b1;
    m_res = '0; m_rd = '0; m_we = 1'b0;
    do_op(32'h400, 0, 5'd10, 32'h8, 2'b01, 0, 1, 1, 3'd2, 0, 0, 0, 32'hCAFEF00D);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 2);
      gd   = $urandom_range(0, 3);
      rvd  = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 2);
      base = $urandom;
      if (kind == 0) begin
        do_op(base, $urandom, 5'($urandom), $urandom, ($urandom_range(0, 1) == 1) ? 2'b10 : 2'($urandom_range(0, 1) * 3),
              0, 0, 1'($urandom), 3'($urandom), 0, 0, 1'($urandom), $urandom);
      end else if (kind == 1) begin
        f3 = 3'($urandom_range(0, 2));
        do_op(base, $urandom, 5'($urandom), $urandom, 2'b00, 1, 0, 1'($urandom), f3,
              gd, 0, 0, 0);
      end else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
        do_op(base, $urandom, 5'($urandom), $urandom, 2'b01, 0, 1, 1'($urandom), f3,
              gd, rvd, 0, $urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
